// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the and/or/not gate-cell BIST engine.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned VEC_W    = 3;
  localparam int unsigned NUM_VECS = 8;

endpackage

// File: rtl/gate_golden_model.sv
// Golden response of the gate cell: {a,b,c} -> {t2,t1,t0} = {~c, a|b, a&b}.
module gate_golden_model (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [2:0] expected
);

  always_comb begin
    expected = {~c, a | b, a & b};
  end

endmodule

// File: rtl/gate_bist.sv
// BIST engine: sweeps all {a,b,c} vectors into the gate cell and counts response mismatches.
// Optional first-failure log ports are built when GATE_BIST_ERR_LOG_EN is defined.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned NUM_PASSES  = 1,
  parameter int unsigned ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             stim_a,
  output logic             stim_b,
  output logic             stim_c,
  input  logic             resp_t0,
  input  logic             resp_t1,
  input  logic             resp_t2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GATE_BIST_ERR_LOG_EN
  ,
  output logic [2:0]       first_fail_vec,
  output logic [2:0]       first_fail_resp
`endif
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0]    PASS_LAST = PW'(NUM_PASSES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST  = VEC_W'(NUM_VECS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] vec_next;
  logic [HW-1:0]    hold_cnt;
  logic [PW-1:0]    pass_cnt;
  logic [2:0]       expected;
  logic [2:0]       resp;
  logic             sample;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  gate_golden_model u_golden (
    .a        (vec[2]),
    .b        (vec[1]),
    .c        (vec[0]),
    .expected (expected)
  );

  always_comb begin
    resp     = {resp_t2, resp_t1, resp_t0};
    sample   = (hold_cnt == HOLD_LAST);
    mismatch = (resp != expected);
    vec_next = vec + VEC_W'(1);
    err_next = err_count;
    if (sample && mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      hold_cnt  <= '0;
      pass_cnt  <= '0;
      stim_a    <= 1'b0;
      stim_b    <= 1'b0;
      stim_c    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
`ifdef GATE_BIST_ERR_LOG_EN
      first_fail_vec  <= '0;
      first_fail_resp <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            err_count <= '0;
            pass      <= 1'b0;
            vec       <= '0;
            hold_cnt  <= '0;
            pass_cnt  <= '0;
            {stim_a, stim_b, stim_c} <= '0;
`ifdef GATE_BIST_ERR_LOG_EN
            first_fail_vec  <= '0;
            first_fail_resp <= '0;
`endif
          end
        end
        RUN: begin
          err_count <= err_next;
`ifdef GATE_BIST_ERR_LOG_EN
          // A zero count before this sample means no earlier mismatch in the run.
          if (sample && mismatch && (err_count == '0)) begin
            first_fail_vec  <= vec;
            first_fail_resp <= resp;
          end
`endif
          if (sample) begin
            hold_cnt <= '0;
            if ((vec == VEC_LAST) && (pass_cnt == PASS_LAST)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              vec   <= '0;
              {stim_a, stim_b, stim_c} <= '0;
            end else begin
              if (vec == VEC_LAST) begin
                pass_cnt <= pass_cnt + PW'(1);
              end
              vec <= vec_next;
              {stim_a, stim_b, stim_c} <= vec_next;
            end
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: four configurations driving behavioural gate cells with selectable faults.
module tb_gate_bist;

  localparam int N = 4;

  // 0: H2/P1, 1: H2/P3, 2: H3/P1, 3: H1/P1
  function automatic int hold_of(input int g);
    case (g)
      2:       return 3;
      3:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int passes_of(input int g);
    return (g == 1) ? 3 : 1;
  endfunction

  // 8 * HOLD_CYCLES * NUM_PASSES, written out per configuration
  function automatic int lat_of(input int g);
    case (g)
      0:       return 16;
      1:       return 48;
      2:       return 24;
      default: return 8;
    endcase
  endfunction

  typedef struct {
    int         id;
    int         acc;
    int         lat;
    logic       pass;
    logic [3:0] err;
    logic [2:0] ffv;
    logic [2:0] ffr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] start;
  logic [N-1:0] sa, sbit, sc, busy, done, pass;
  logic [N-1:0][3:0] err;
`ifdef GATE_BIST_ERR_LOG_EN
  logic [N-1:0][2:0] ffv, ffr;
`endif
  int fm [N];  // 0 good, 1 t0 stuck-at-1, 2 all outputs inverted, 3 two-register latency
  int bcnt [N];

  exp_t scb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;
  int   pushed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [2:0] p1, p2, src;
    logic       r0, r1, r2;

    always @(posedge clk) begin
      p1 <= {sa[g], sbit[g], sc[g]};
      p2 <= p1;
    end

    always_comb begin
      src = (fm[g] == 3) ? p2 : {sa[g], sbit[g], sc[g]};
      r0  = src[2] & src[1];
      r1  = src[2] | src[1];
      r2  = ~src[0];
      if (fm[g] == 1) r0 = 1'b1;
      if (fm[g] == 2) {r2, r1, r0} = ~{r2, r1, r0};
    end

    gate_bist #(
      .HOLD_CYCLES (hold_of(g)),
      .NUM_PASSES  (passes_of(g)),
      .ERR_W       (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .stim_a    (sa[g]),
      .stim_b    (sbit[g]),
      .stim_c    (sc[g]),
      .resp_t0   (r0),
      .resp_t1   (r1),
      .resp_t2   (r2),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (err[g])
`ifdef GATE_BIST_ERR_LOG_EN
      ,
      .first_fail_vec  (ffv[g]),
      .first_fail_resp (ffr[g])
`endif
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation for every done pulse.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (!rst_n) bcnt[g] = 0;
      else if (busy[g]) bcnt[g]++;
      if (done[g]) begin
        done_seen++;
        if (scb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: instance %0d pulsed done with nothing expected (cycle %0d)", g, cyc);
        end else begin
          mon_e = scb.pop_front();
          chk("done_instance", g, mon_e.id);
          chk("done_cycle", cyc, mon_e.acc + mon_e.lat);
          chk("busy_cycles", bcnt[g], mon_e.lat);
          chk("pass", int'(pass[g]), int'(mon_e.pass));
          chk("err_count", int'(err[g]), int'(mon_e.err));
`ifdef GATE_BIST_ERR_LOG_EN
          chk("first_fail_vec", int'(ffv[g]), int'(mon_e.ffv));
          chk("first_fail_resp", int'(ffr[g]), int'(mon_e.ffr));
`endif
        end
        bcnt[g] = 0;
      end
    end
  end

  task automatic push_exp(input int id, input int acc, input logic p, input logic [3:0] e,
                          input logic [2:0] fv, input logic [2:0] fr);
    exp_t x;
    x.id = id; x.acc = acc; x.lat = lat_of(id);
    x.pass = p; x.err = e; x.ffv = fv; x.ffr = fr;
    scb.push_back(x);
    pushed++;
  endtask

  task automatic launch(input int id, input int mode, input logic p, input logic [3:0] e,
                        input logic [2:0] fv, input logic [2:0] fr);
    @(negedge clk);
    fm[id] = mode;
    start[id] = 1'b1;
    push_exp(id, cyc + 1, p, e, fv, fr);
    @(negedge clk);
    start[id] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && scb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", scb.size(), 0);
    scb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = '0;
    for (int g = 0; g < N; g++) fm[g] = 0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      chk("rst_stim", int'({sa[g], sbit[g], sc[g]}), 0);
      chk("rst_busy", int'(busy[g]), 0);
      chk("rst_done", int'(done[g]), 0);
      chk("rst_pass", int'(pass[g]), 0);
      chk("rst_err", int'(err[g]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good cell, then results hold in IDLE
    launch(0, 0, 1'b1, 4'd0, 3'b000, 3'b000);
    drain();
    repeat (5) @(negedge clk);
    chk("idle_hold_pass", int'(pass[0]), 1);
    chk("idle_hold_busy", int'(busy[0]), 0);

    // AND output stuck-at-1: vectors 0..5 fail, first is 000 with {t2,t1,t0}=101
    launch(0, 1, 1'b0, 4'd6, 3'b000, 3'b101);
    drain();
    repeat (5) @(negedge clk);
    chk("idle_hold_err", int'(err[0]), 6);

    // All outputs inverted: 8 mismatches
    launch(0, 2, 1'b0, 4'd8, 3'b000, 3'b011);
    drain();

    // Inverted over 3 passes: 24 mismatches saturate at 15
    launch(1, 2, 1'b0, 4'd15, 3'b000, 3'b011);
    drain();

    // Two-register cell latency: HOLD_CYCLES=3 passes, HOLD_CYCLES=1 fails on vectors 1,2,3,6,7
    launch(2, 3, 1'b1, 4'd0, 3'b000, 3'b000);
    drain();
    launch(3, 3, 1'b0, 4'd5, 3'b001, 3'b100);
    drain();

    // Reset mid-run aborts without a done pulse
    @(negedge clk);
    fm[0] = 2;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_stim", int'({sa[0], sbit[0], sc[0]}), 0);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_done", int'(done[0]), 0);
    chk("abort_pass", int'(pass[0]), 0);
    chk("abort_err", int'(err[0]), 0);
    repeat (30) @(negedge clk);
    launch(0, 0, 1'b1, 4'd0, 3'b000, 3'b000);
    drain();

    // start re-pulsed during RUN and on the done cycle is ignored
    launch(0, 0, 1'b1, 4'd0, 3'b000, 3'b000);
    repeat (4) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 100 && !done[0]; i++) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (40) @(negedge clk);
    chk("repulse_pending", scb.size(), 0);

    // start held high: a new run begins from IDLE each time
    @(negedge clk);
    fm[0] = 1;
    start[0] = 1'b1;
    push_exp(0, cyc + 1, 1'b0, 4'd6, 3'b000, 3'b101);
    push_exp(0, cyc + 19, 1'b0, 4'd6, 3'b000, 3'b101);
    repeat (19) @(negedge clk);
    start[0] = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    chk("done_total", done_seen, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
